serial_add_ctrl: RTL and testbench

Bit-serial multi-bit adder controller that reuses one single-bit adder cell across WIDTH clock cycles. It latches two WIDTH-bit operands and a carry-in on a start request, feeds the adder cell one bit pair per cycle (LSB first), and collects the sum bits. It then presents the registered result with a one-cycle done pulse. It sits above the existing half-adder datapath and is the sequencer that turns that cell into a word-wide adder.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/full_adder_bit.sv | 13 +
 rtl/half_adder.sv | 10 +
 rtl/serial_add_ctrl.sv | 76 +++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and width limits for the bit-serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational full adder built from two half adders and an OR.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    logic s0, c0, c1;
    half_adder u_ha0 (.x(x),  .y(y), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(c), .s(s),  .c(c1));
    assign co = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell over WIDTH cycles, LSB first,
// to form a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c, last;

    full_adder_bit u_fa (.x(a_sh[0]), .y(b_sh[0]), .c(carry), .s(fa_s), .co(fa_c));

    assign last = cnt == CW'(WIDTH - 1);

    // Unused encoding 2'd3 falls through to IDLE.
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last  ? DONE  : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == SHIFT;
            done  <= state_nx == DONE;
            if (state == IDLE && start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
                carry <= fa_c;
                cnt   <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    sum  <= {fa_s, r_sh[WIDTH-1:1]};
                    cout <= fa_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table-driven and directed checks of serial_add_ctrl at WIDTH=8
// and an exhaustive sweep of a WIDTH=2 build.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] prev_sum = '0;
    logic       prev_cout = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one operation, checks latency, busy length, output hold and result.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input string nm);
        int k, bc;
        logic held;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        k = 0; bc = 0; held = 1'b1;
        while (!done && k < 40) begin
            bc += int'(busy);
            if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, k, 8);
        chk({nm, " busy cycles"}, bc, 8);
        chk({nm, " hold"}, {31'd0, held}, 1);
        chk({nm, " busy&done"}, {31'd0, busy & done}, 0);
        chk({nm, " sum"}, {24'd0, sum}, {24'd0, es});
        chk({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
        prev_sum = es; prev_cout = ec;
        @(negedge clk);
        chk({nm, " done pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        tv[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tv[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        tv[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset sum", {24'd0, sum}, 0);
        chk("reset cout", {31'd0, cout}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) op8(tv[i].a, tv[i].b, tv[i].cin, tv[i].s, tv[i].co, $sformatf("v%0d", i));

        // Extra start pulses with changed operands during SHIFT and DONE must be ignored.
        begin
            int dc;
            logic [7:0] cap_s;
            logic cap_c;
            dc = 0; cap_s = '0; cap_c = 1'b1;
            @(negedge clk);
            a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 26; k++) begin
                if (done) begin dc++; cap_s = sum; cap_c = cout; end
                start = (k == 3 || k == 8);
                a = start ? 8'hFF : a;
                b = start ? 8'hFF : b;
                @(negedge clk);
            end
            start = 1'b0;
            chk("ignore done count", dc, 1);
            chk("ignore sum", {24'd0, cap_s}, 32'h46);
            chk("ignore cout", {31'd0, cap_c}, 0);
            chk("ignore idle busy", {31'd0, busy}, 0);
            prev_sum = 8'h46; prev_cout = 1'b0;
        end

        // Reset in the middle of an operation.
        begin
            int dc;
            dc = 0;
            @(negedge clk);
            a = 8'hF0; b = 8'h10; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst busy", {31'd0, busy}, 0);
            chk("midrst done", {31'd0, done}, 0);
            chk("midrst sum", {24'd0, sum}, 0);
            chk("midrst cout", {31'd0, cout}, 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (12) begin
                @(negedge clk);
                dc += int'(done);
            end
            chk("midrst no done", dc, 0);
            prev_sum = '0; prev_cout = 1'b0;
            op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after rst");
        end

        // Exhaustive WIDTH=2 sweep.
        for (int v = 0; v < 32; v++) begin
            int k;
            logic [2:0] exp3;
            exp3 = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
            @(negedge clk);
            a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4]; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; a2 = ~a2; b2 = ~b2;
            k = 0;
            while (!done2 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("w2 %0d result", v), {29'd0, cout2, sum2}, {29'd0, exp3});
            chk($sformatf("w2 %0d latency", v), k, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
